// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement buffer placed directly upstream of the register file.
//   Issue allocates entries in program order. Execution units post results by
//   tag, in any order. Completed entries are committed strictly from the head
//   and drive the register-file write port.
//
// Ports
//   clk_in, rst_in       clock, synchronous active-high reset
//   flush_in             synchronous squash of every entry (mispredict)
//   alloc_valid/_rd/_has_dest -> alloc_tag   allocation request and granted tag
//   rob_full, rob_empty  occupancy flags derived from the registered count
//   wb_valid/_tag/_data  out-of-order result writeback
//   query_tag -> query_ready/query_data      operand lookup on registered state
//   write_or_not, writeaddr, writedata       registered register-file write port
//   commit_valid, commit_tag                 registered retirement report
//
// Handshake: an allocation is accepted on a rising edge where
// alloc_valid && !rob_full. When the buffer is full the request is dropped,
// and issue must hold it until it is accepted. wb_valid and commit_valid are
// single-cycle pulses with no back-pressure.

module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             flush_in,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   input  logic             alloc_has_dest,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             rob_full,
   output logic             rob_empty,
   input  logic             wb_valid,
   input  logic [TAG_W-1:0] wb_tag,
   input  logic [31:0]      wb_data,
   input  logic [TAG_W-1:0] query_tag,
   output logic             query_ready,
   output logic [31:0]      query_data,
   output logic             write_or_not,
   output logic [4:0]       writeaddr,
   output logic [31:0]      writedata,
   output logic             commit_valid,
   output logic [TAG_W-1:0] commit_tag
);

   localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] ready_q;
   logic [DEPTH-1:0] has_dest_q;
   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [TAG_W-1:0] head_q;
   logic [TAG_W-1:0] tail_q;
   logic [TAG_W:0]   count_q;
   logic             alloc_ok;
   logic             commit_ok;
   logic             squash;

   assign squash      = rst_in | flush_in;
   assign rob_full    = (count_q == FULL_COUNT);
   assign rob_empty   = (count_q == '0);
   assign alloc_tag   = tail_q;
   // Fullness comes from the registered count, so a full buffer refuses
   // allocation even in a cycle where the head retires.
   assign alloc_ok    = alloc_valid & ~rob_full;
   assign commit_ok   = busy_q[head_q] & ready_q[head_q];
   assign query_ready = busy_q[query_tag] & ready_q[query_tag];
   assign query_data  = data_q[query_tag];

   // Status bits. Allocation and commit never target the same entry: if
   // head == tail with the head busy, the buffer is full and allocation is
   // refused. Commit is written last so it wins over a writeback to the head.
   always_ff @(posedge clk_in) begin
      if (squash) begin
         busy_q  <= '0;
         ready_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_ok && tail_q == TAG_W'(i)) begin
               busy_q[i]  <= 1'b1;
               ready_q[i] <= 1'b0;
            end
            if (wb_valid && busy_q[i] && wb_tag == TAG_W'(i))
               ready_q[i] <= 1'b1;
            if (commit_ok && head_q == TAG_W'(i)) begin
               busy_q[i]  <= 1'b0;
               ready_q[i] <= 1'b0;
            end
         end
      end
   end

   // Payload needs no reset. It is only observed through busy/ready.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_ok && tail_q == TAG_W'(i)) begin
            rd_q[i]       <= alloc_rd;
            has_dest_q[i] <= alloc_has_dest & (alloc_rd != 5'd0);
         end
         if (wb_valid && busy_q[i] && wb_tag == TAG_W'(i))
            data_q[i] <= wb_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (squash) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + TAG_W'(commit_ok);
         tail_q  <= tail_q + TAG_W'(alloc_ok);
         count_q <= count_q + (TAG_W+1)'(alloc_ok) - (TAG_W+1)'(commit_ok);
      end
   end

   // Register-file port. The address, data and tag hold between commits.
   // Only reset clears them; a flush does not.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         write_or_not <= 1'b0;
         writeaddr    <= '0;
         writedata    <= '0;
         commit_valid <= 1'b0;
         commit_tag   <= '0;
      end else if (flush_in || !commit_ok) begin
         write_or_not <= 1'b0;
         commit_valid <= 1'b0;
      end else begin
         write_or_not <= has_dest_q[head_q];
         writeaddr    <= rd_q[head_q];
         writedata    <= data_q[head_q];
         commit_valid <= 1'b1;
         commit_tag   <= head_q;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

   localparam int DEPTH = 16;
   localparam int TAG_W = 4;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic             flush_in = 1'b0;
   logic             alloc_valid = 1'b0;
   logic [4:0]       alloc_rd = '0;
   logic             alloc_has_dest = 1'b0;
   logic [TAG_W-1:0] alloc_tag;
   logic             rob_full;
   logic             rob_empty;
   logic             wb_valid = 1'b0;
   logic [TAG_W-1:0] wb_tag = '0;
   logic [31:0]      wb_data = '0;
   logic [TAG_W-1:0] query_tag = '0;
   logic             query_ready;
   logic [31:0]      query_data;
   logic             write_or_not;
   logic [4:0]       writeaddr;
   logic [31:0]      writedata;
   logic             commit_valid;
   logic [TAG_W-1:0] commit_tag;

   int checks = 0;
   int failures = 0;

   // Expected commits in retirement order: {write_or_not, writeaddr, writedata, commit_tag}
   logic [41:0] exp_q[$];

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_has_dest(alloc_has_dest),
      .alloc_tag(alloc_tag), .rob_full(rob_full), .rob_empty(rob_empty),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .query_tag(query_tag), .query_ready(query_ready), .query_data(query_data),
      .write_or_not(write_or_not), .writeaddr(writeaddr), .writedata(writedata),
      .commit_valid(commit_valid), .commit_tag(commit_tag)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one edge, then release all single-cycle request inputs.
   task automatic tick();
      @(posedge clk_in);
      #1;
      alloc_valid = 1'b0;
      wb_valid    = 1'b0;
      flush_in    = 1'b0;
   endtask

   task automatic set_alloc(input logic [4:0] rd, input logic has_dest);
      alloc_valid    = 1'b1;
      alloc_rd       = rd;
      alloc_has_dest = has_dest;
   endtask

   task automatic set_wb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
      wb_valid = 1'b1;
      wb_tag   = tag;
      wb_data  = data;
   endtask

   task automatic expect_commit(input logic wen, input logic [4:0] rd,
                                input logic [31:0] data, input logic [TAG_W-1:0] tag);
      exp_q.push_back({wen, rd, data, tag});
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk_in) begin
      if (commit_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit: got tag %0d rd %0d data 0x%0h, expected none",
                     commit_tag, writeaddr, writedata);
         end else begin
            logic [41:0] e;
            e = exp_q.pop_front();
            chk("commit", {22'd0, write_or_not, writeaddr, writedata, commit_tag}, {22'd0, e});
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset for two cycles.
      rst_in = 1'b1;
      tick();
      tick();
      chk("rst_write_or_not", 64'(write_or_not), 64'd0);
      chk("rst_writeaddr",    64'(writeaddr),    64'd0);
      chk("rst_writedata",    64'(writedata),    64'd0);
      chk("rst_commit_valid", 64'(commit_valid), 64'd0);
      chk("rst_commit_tag",   64'(commit_tag),   64'd0);
      chk("rst_rob_empty",    64'(rob_empty),    64'd1);
      chk("rst_rob_full",     64'(rob_full),     64'd0);
      chk("rst_alloc_tag",    64'(alloc_tag),    64'd0);
      chk("rst_query_ready",  64'(query_ready),  64'd0);
      rst_in = 1'b0;

      // Single op: alloc at A, writeback at A+1, commit visible after A+2.
      set_alloc(5'd5, 1'b1);
      chk("single_alloc_tag", 64'(alloc_tag), 64'd0);
      tick();
      chk("single_not_empty", 64'(rob_empty), 64'd0);
      expect_commit(1'b1, 5'd5, 32'hDEAD_BEEF, 4'd0);
      set_wb(4'd0, 32'hDEAD_BEEF);
      tick();
      query_tag = 4'd0;
      #0;
      chk("single_query_ready", 64'(query_ready), 64'd1);
      chk("single_query_data",  64'(query_data),  64'hDEAD_BEEF);
      tick();
      chk("single_wen",   64'(write_or_not), 64'd1);
      chk("single_waddr", 64'(writeaddr),    64'd5);
      chk("single_wdata", 64'(writedata),    64'hDEAD_BEEF);
      chk("single_ctag",  64'(commit_tag),   64'd0);
      chk("single_empty", 64'(rob_empty),    64'd1);
      tick();
      chk("single_wen_drop",   64'(write_or_not), 64'd0);
      chk("single_waddr_hold", 64'(writeaddr),    64'd5);

      // Out-of-order writeback, in-order retirement.
      flush_in = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         set_alloc(5'(i + 1), 1'b1);
         chk("ooo_alloc_tag", 64'(alloc_tag), 64'(i));
         tick();
      end
      expect_commit(1'b1, 5'd1, 32'h10, 4'd0);
      expect_commit(1'b1, 5'd2, 32'h20, 4'd1);
      expect_commit(1'b1, 5'd3, 32'h30, 4'd2);
      set_wb(4'd2, 32'h30);
      tick();
      chk("ooo_no_commit_a", 64'(commit_valid), 64'd0);
      set_wb(4'd0, 32'h10);
      tick();
      chk("ooo_no_commit_b", 64'(commit_valid), 64'd0);
      set_wb(4'd1, 32'h20);
      tick();
      chk("ooo_c0_data", 64'(writedata), 64'h10);
      tick();
      chk("ooo_c1_data", 64'(writedata), 64'h20);
      tick();
      chk("ooo_c2_data", 64'(writedata), 64'h30);
      chk("ooo_c2_valid", 64'(commit_valid), 64'd1);
      tick();
      chk("ooo_empty", 64'(rob_empty), 64'd1);

      // Full and wrap.
      flush_in = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         set_alloc(5'(i + 1), 1'b1);
         chk("full_alloc_tag", 64'(alloc_tag), 64'(i));
         tick();
      end
      chk("full_flag", 64'(rob_full), 64'd1);
      set_alloc(5'd20, 1'b1);
      tick();
      chk("full_17th_ignored", 64'(rob_full), 64'd1);
      chk("full_tail_hold", 64'(alloc_tag), 64'd0);
      expect_commit(1'b1, 5'd1, 32'h100, 4'd0);
      set_wb(4'd0, 32'h100);
      tick();
      // Head commits at this edge; the allocation is still refused.
      set_alloc(5'd21, 1'b1);
      tick();
      chk("full_refused_while_commit", 64'(rob_full), 64'd0);
      chk("wrap_alloc_tag", 64'(alloc_tag), 64'd0);
      set_alloc(5'd21, 1'b1);
      tick();
      chk("wrap_refull", 64'(rob_full), 64'd1);
      for (int t = 1; t < DEPTH; t++) begin
         expect_commit(1'b1, 5'(t + 1), 32'h200 + 32'(t), 4'(t));
         set_wb(4'(t), 32'h200 + 32'(t));
         tick();
      end
      expect_commit(1'b1, 5'd21, 32'h300, 4'd0);
      set_wb(4'd0, 32'h300);
      tick();
      tick();
      tick();
      chk("wrap_drained", 64'(rob_empty), 64'd1);

      // rd=x0 with has_dest, and a store without a destination. head = tail = 1.
      set_alloc(5'd0, 1'b1);
      tick();
      set_alloc(5'd7, 1'b0);
      tick();
      expect_commit(1'b0, 5'd0, 32'h55, 4'd1);
      expect_commit(1'b0, 5'd7, 32'h66, 4'd2);
      set_wb(4'd1, 32'h55);
      tick();
      set_wb(4'd2, 32'h66);
      tick();
      chk("x0_commit_valid", 64'(commit_valid), 64'd1);
      chk("x0_wen", 64'(write_or_not), 64'd0);
      tick();
      chk("nodest_commit_valid", 64'(commit_valid), 64'd1);
      chk("nodest_wen", 64'(write_or_not), 64'd0);
      tick();

      // Flush mid-flight: tags 3..7 allocated, 4 and 6 ready, head not ready.
      for (int i = 0; i < 5; i++) begin
         set_alloc(5'(10 + i), 1'b1);
         tick();
      end
      set_wb(4'd4, 32'h44);
      tick();
      set_wb(4'd6, 32'h66);
      tick();
      flush_in = 1'b1;
      set_wb(4'd3, 32'h33);
      set_alloc(5'd12, 1'b1);
      tick();
      query_tag = 4'd4;
      #0;
      chk("flush_empty", 64'(rob_empty), 64'd1);
      chk("flush_wen", 64'(write_or_not), 64'd0);
      chk("flush_cvalid", 64'(commit_valid), 64'd0);
      chk("flush_alloc_tag", 64'(alloc_tag), 64'd0);
      chk("flush_query_ready", 64'(query_ready), 64'd0);
      // Stale writeback to an idle tag must be dropped.
      set_wb(4'd0, 32'hBAD);
      tick();
      set_alloc(5'd9, 1'b1);
      tick();
      query_tag = 4'd0;
      #0;
      chk("stale_wb_ignored", 64'(query_ready), 64'd0);
      tick();
      chk("stale_no_commit", 64'(commit_valid), 64'd0);
      expect_commit(1'b1, 5'd9, 32'h77, 4'd0);
      set_wb(4'd0, 32'h77);
      tick();
      tick();
      chk("post_flush_wdata", 64'(writedata), 64'h77);
      tick();
      tick();

      // ---------------- report ----------------
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
